uart_frame_parser: RTL and testbench

//  Consumes bytes from the UART receiver (uart_done/uart_data) and parses frames 0x55 0xAA LEN PAYLOAD[LEN] CSUM.

---
 rtl/uart_frame_pkg.sv | 20 ++
 rtl/uart_byte_fifo.sv | 47 ++++
 rtl/uart_frame_parser.sv | 140 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared FSM encoding, sync bytes and error codes for the UART frame parser
package uart_frame_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR2,
      ST_LEN,
      ST_PAYLOAD,
      ST_CSUM
   } state_t;

   localparam logic [7:0] SYNC0 = 8'h55;
   localparam logic [7:0] SYNC1 = 8'hAA;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_LEN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - first-word-fall-through byte FIFO for frame payload
module uart_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   // A pop frees the head slot in the same cycle, so a push while full still lands.
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge sys_clk) begin
      if (do_push) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/uart_frame_parser.sv
// rtl/uart_frame_parser.sv - parses 55 AA LEN PAYLOAD CSUM frames from the UART receiver into a payload FIFO
module uart_frame_parser
   import uart_frame_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int UART_BPS   = 9600,
   parameter int MAX_LEN    = 64,
   parameter int FIFO_DEPTH = 16
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       uart_done,
   input  logic [7:0] uart_data,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       frame_ok,
   output logic       frame_err,
   output logic [1:0] err_code,
   output logic       overflow
);

   localparam int unsigned TIMEOUT_CYC = 32'((64'd20 * 64'(CLK_FREQ)) / 64'(UART_BPS));
   localparam int          TW          = $clog2(TIMEOUT_CYC + 1);

   state_t          state_q, state_d;
   logic            uart_done_d;
   logic            byte_stb;
   logic [TW-1:0]   to_cnt;
   logic            timeout_hit;
   logic [7:0]      rem_q, rem_d;
   logic [7:0]      sum_q, sum_d;
   logic            ok_d, err_d;
   logic [1:0]      code_d;
   logic            push;
   logic            pop;
   logic            fifo_full;
   logic            fifo_empty;

   assign byte_stb    = uart_done & ~uart_done_d;
   assign timeout_hit = (state_q != ST_IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));
   assign m_valid     = ~fifo_empty;
   assign pop         = m_ready & m_valid;

   uart_byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .push      (push),
      .din       (uart_data),
      .pop       (pop),
      .dout      (m_data),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      sum_d   = sum_q;
      ok_d    = 1'b0;
      err_d   = 1'b0;
      code_d  = err_code;
      push    = 1'b0;
      // Timeout takes priority: a byte arriving on the expiry cycle is discarded.
      if (timeout_hit) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
      end else if (byte_stb) begin
         case (state_q)
            ST_IDLE: begin
               if (uart_data == SYNC0) state_d = ST_HDR2;
            end
            ST_HDR2: begin
               if (uart_data == SYNC1)      state_d = ST_LEN;
               else if (uart_data != SYNC0) state_d = ST_IDLE;
            end
            ST_LEN: begin
               rem_d = uart_data;
               sum_d = uart_data;
               if (uart_data == 8'd0) begin
                  state_d = ST_CSUM;
               end else if (int'(uart_data) > MAX_LEN) begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
               end else begin
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               push  = 1'b1;
               sum_d = sum_q + uart_data;
               rem_d = rem_q - 8'd1;
               if (rem_q == 8'd1) state_d = ST_CSUM;
            end
            ST_CSUM: begin
               state_d = ST_IDLE;
               if (uart_data == sum_q) begin
                  ok_d   = 1'b1;
                  code_d = ERR_NONE;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_CSUM;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q     <= ST_IDLE;
         uart_done_d <= 1'b0;
         to_cnt      <= '0;
         rem_q       <= '0;
         sum_q       <= '0;
         frame_ok    <= 1'b0;
         frame_err   <= 1'b0;
         err_code    <= ERR_NONE;
         overflow    <= 1'b0;
      end else begin
         state_q     <= state_d;
         uart_done_d <= uart_done;
         rem_q       <= rem_d;
         sum_q       <= sum_d;
         frame_ok    <= ok_d;
         frame_err   <= err_d;
         err_code    <= code_d;
         if (state_q == ST_IDLE || byte_stb || timeout_hit) to_cnt <= '0;
         else                                               to_cnt <= to_cnt + 1'b1;
         if (push && fifo_full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_frame_parser.sv
// tb/tb_uart_frame_parser.sv - scoreboard bench for uart_frame_parser with directed frames
module tb_uart_frame_parser;

   logic       sys_clk   = 1'b0;
   logic       sys_rst_n = 1'b0;
   logic       uart_done = 1'b0;
   logic [7:0] uart_data = 8'h00;
   logic       m_ready   = 1'b0;
   logic [7:0] m_data;
   logic       m_valid;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       overflow;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] exp_data [$];
   logic [2:0] exp_evt  [$];
   logic [7:0] seq      [$];

   // TIMEOUT_CYC = 20*50e6/200000 = 5000 cycles
   uart_frame_parser #(
      .CLK_FREQ   (50000000),
      .UART_BPS   (200000),
      .MAX_LEN    (64),
      .FIFO_DEPTH (16)
   ) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .uart_done (uart_done),
      .uart_data (uart_data),
      .m_data    (m_data),
      .m_valid   (m_valid),
      .m_ready   (m_ready),
      .frame_ok  (frame_ok),
      .frame_err (frame_err),
      .err_code  (err_code),
      .overflow  (overflow)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Monitor: event code is {is_ok, err_code}
   always @(negedge sys_clk) begin
      if (sys_rst_n) begin
         if (m_valid && m_ready) begin
            if (exp_data.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_data: got %0h, expected none", m_data);
            end else begin
               check("m_data", 32'(m_data), 32'(exp_data.pop_front()));
            end
         end
         if (frame_ok || frame_err) begin
            if (exp_evt.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL unexpected_pulse: got ok=%0b err=%0b code=%0d, expected none",
                        frame_ok, frame_err, err_code);
            end else begin
               logic [2:0] e;
               e = exp_evt.pop_front();
               check("frame_ok", 32'(frame_ok), 32'(e[2]));
               check("frame_err", 32'(frame_err), 32'(!e[2]));
               check("err_code", 32'(err_code), 32'(e[1:0]));
            end
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input int hold);
      @(negedge sys_clk);
      uart_data = b;
      uart_done = 1'b1;
      repeat (hold) @(negedge sys_clk);
      uart_done = 1'b0;
      repeat (2) @(negedge sys_clk);
   endtask

   task automatic send_seq(input logic [7:0] s [$], input int hold);
      foreach (s[i]) send_byte(s[i], hold);
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k = 0;
      while ((exp_data.size() != 0 || exp_evt.size() != 0) && k < budget) begin
         @(negedge sys_clk);
         k++;
      end
      check({name, "_pending"}, 32'(exp_data.size() + exp_evt.size()), 32'd0);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(negedge sys_clk);
      check("rst_m_valid", 32'(m_valid), 32'd0);
      check("rst_m_data", 32'(m_data), 32'd0);
      check("rst_frame_ok", 32'(frame_ok), 32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_err_code", 32'(err_code), 32'd0);
      check("rst_overflow", 32'(overflow), 32'd0);
      sys_rst_n = 1'b1;
      m_ready   = 1'b1;

      // 1: good frame, 3+1+2+3 = 9
      exp_data.push_back(8'h01); exp_data.push_back(8'h02); exp_data.push_back(8'h03);
      exp_evt.push_back(3'b100);
      seq = {8'h55, 8'hAA, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
      send_seq(seq, 3);
      wait_drain("t1", 200);

      // 2: checksum error, expected sum 0x32
      exp_data.push_back(8'h10); exp_data.push_back(8'h20);
      exp_evt.push_back(3'b001);
      seq = {8'h55, 8'hAA, 8'h02, 8'h10, 8'h20, 8'h00};
      send_seq(seq, 3);
      wait_drain("t2", 200);

      // 3: LEN 65 > MAX_LEN, then an empty frame
      exp_evt.push_back(3'b010);
      seq = {8'h55, 8'hAA, 8'h41};
      send_seq(seq, 3);
      wait_drain("t3_len", 200);
      check("t3_m_valid", 32'(m_valid), 32'd0);
      exp_evt.push_back(3'b100);
      seq = {8'h55, 8'hAA, 8'h00, 8'h00};
      send_seq(seq, 3);
      wait_drain("t3_ok", 200);

      // 4: stall mid-payload until timeout
      exp_data.push_back(8'h11);
      exp_evt.push_back(3'b011);
      seq = {8'h55, 8'hAA, 8'h05, 8'h11};
      send_seq(seq, 3);
      repeat (4000) @(negedge sys_clk);
      check("t4_no_early_timeout", 32'(exp_evt.size()), 32'd1);
      wait_drain("t4_timeout", 2000);
      exp_evt.push_back(3'b100);
      seq = {8'h00, 8'h55, 8'hAA, 8'h00, 8'h00};
      send_seq(seq, 3);
      wait_drain("t4_idle", 200);

      // 5: LEN 20 into a 16-deep FIFO with no consumer; sum 0x14+210 = 0xE6
      m_ready = 1'b0;
      exp_evt.push_back(3'b100);
      seq = {8'h55, 8'hAA, 8'h14};
      for (int i = 1; i <= 20; i++) seq.push_back(8'(i));
      seq.push_back(8'hE6);
      send_seq(seq, 3);
      wait_drain("t5_frame", 200);
      check("t5_overflow", 32'(overflow), 32'd1);
      check("t5_m_valid_full", 32'(m_valid), 32'd1);
      for (int i = 1; i <= 16; i++) exp_data.push_back(8'(i));
      m_ready = 1'b1;
      wait_drain("t5_drain", 200);
      check("t5_m_valid_empty", 32'(m_valid), 32'd0);

      // 6: long uart_done level, repeated first sync byte
      exp_data.push_back(8'h7E);
      exp_evt.push_back(3'b100);
      seq = {8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
      send_seq(seq, 2604);
      wait_drain("t6", 200);

      // reset in the middle of a payload
      m_ready = 1'b0;
      seq = {8'h55, 8'hAA, 8'h05, 8'h11, 8'h22};
      send_seq(seq, 3);
      check("mid_m_valid", 32'(m_valid), 32'd1);
      @(negedge sys_clk);
      sys_rst_n = 1'b0;
      #1;
      check("mid_rst_m_valid", 32'(m_valid), 32'd0);
      check("mid_rst_m_data", 32'(m_data), 32'd0);
      check("mid_rst_overflow", 32'(overflow), 32'd0);
      check("mid_rst_err_code", 32'(err_code), 32'd0);
      check("mid_rst_pulses", 32'({frame_ok, frame_err}), 32'd0);
      repeat (3) @(negedge sys_clk);
      sys_rst_n = 1'b1;
      m_ready   = 1'b1;
      exp_data.push_back(8'h42);
      exp_evt.push_back(3'b100);
      seq = {8'h55, 8'hAA, 8'h01, 8'h42, 8'h43};
      send_seq(seq, 3);
      wait_drain("post_rst", 200);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
